// File: rtl/sr_flag_arbiter_pkg.sv
// Shared types and constants for the SR flag arbiter.
// Holds the FSM state encoding and the default geometry.
package sr_flag_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  // Index width for a pointer over n requesters (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_flag_bank.sv
// Bank of WIDTH clocked SR flags with a shared enable.
// S and R arrive mutually exclusive, so each bit only ever sets, clears or holds.
module sr_flag_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= (q | s) & ~r;
    end
  end

  assign q_bar = ~q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter applying one requester's set/clear masks to a shared flag bank.
// state | meaning
// IDLE  | waiting for a request; picks a winner from ptr when req != 0
// APPLY | winner granted, latched masks written to the flag bank this cycle
module sr_flag_arbiter
  import sr_flag_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] set_mask,
  input  logic [NREQ*WIDTH-1:0] clr_mask,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic                  err,
  output logic [WIDTH-1:0]      flags,
  output logic [WIDTH-1:0]      flags_bar
);

  localparam int PW = ptr_width(NREQ);

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, win_q, win_d, idx;
  logic             found;
  logic [WIDTH-1:0] set_q, clr_q;
  logic             apply;

  // Round-robin search starting at ptr.
  always_comb begin
    win_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win_d = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      win_q <= '0;
      gnt   <= '0;
      set_q <= '0;
      clr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            win_q <= win_d;
            gnt   <= NREQ'(1) << win_d;
            set_q <= set_mask[win_d*WIDTH +: WIDTH];
            clr_q <= clr_mask[win_d*WIDTH +: WIDTH];
          end
        end
        APPLY: begin
          gnt   <= '0;
          ptr_q <= (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
        end
        default: gnt <= '0;
      endcase
    end
  end

  assign apply = (state_q == APPLY);
  assign done  = apply;
  assign err   = apply & (|(set_q & clr_q));

  // Conflicting bits are stripped from both S and R so they simply hold.
  sr_flag_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .rst  (rst),
    .en   (apply),
    .s    (set_q & ~clr_q & {WIDTH{apply}}),
    .r    (clr_q & ~set_q & {WIDTH{apply}}),
    .q    (flags),
    .q_bar(flags_bar)
  );

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: reset, set/clear, round-robin, conflict and mid-command reset.
module tb_sr_flag_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] set_mask, clr_mask;
  logic [3:0]  gnt;
  logic        done, err;
  logic [7:0]  flags, flags_bar;

  int checks = 0;
  int errors = 0;

  sr_flag_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .set_mask (set_mask),
    .clr_mask (clr_mask),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .flags    (flags),
    .flags_bar(flags_bar)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    set_mask = '0;
    clr_mask = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (flags !== 8'h00) begin errors++; $display("FAIL reset_flags: got %h expected 00", flags); end
    checks++; if (flags_bar !== 8'hFF) begin errors++; $display("FAIL reset_flags_bar: got %h expected ff", flags_bar); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b expected 00", done, err); end
  endtask

  task automatic test_set();
    req = 4'b0001;
    set_mask[7:0] = 8'hA5;
    tick();
    checks++; if (gnt !== 4'b0001 || done !== 1'b1) begin errors++; $display("FAIL set_grant: got gnt=%b done=%b expected 0001/1", gnt, done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL set_err: got %b expected 0", err); end
    checks++; if (flags !== 8'h00) begin errors++; $display("FAIL set_early_flags: got %h expected 00", flags); end
    req = '0;
    set_mask[7:0] = 8'hFF;
    tick();
    checks++; if (flags !== 8'hA5 || flags_bar !== 8'h5A) begin errors++; $display("FAIL set_flags: got %h/%h expected a5/5a", flags, flags_bar); end
    checks++; if (gnt !== 4'b0000 || done !== 1'b0) begin errors++; $display("FAIL set_release: got gnt=%b done=%b expected 0000/0", gnt, done); end
    set_mask = '0;
  endtask

  task automatic test_clear();
    req = 4'b0100;
    set_mask[23:16] = 8'h00;
    clr_mask[23:16] = 8'h0F;
    tick();
    checks++; if (gnt !== 4'b0100 || done !== 1'b1) begin errors++; $display("FAIL clr_grant: got gnt=%b done=%b expected 0100/1", gnt, done); end
    req = '0;
    tick();
    checks++; if (flags !== 8'hA0) begin errors++; $display("FAIL clr_flags: got %h expected a0", flags); end
    clr_mask = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (gnt !== order[i] || done !== 1'b1) begin errors++; $display("FAIL rr_grant_%0d: got gnt=%b done=%b expected %b/1", i, gnt, done, order[i]); end
      tick();
      checks++; if (gnt !== 4'b0000 || done !== 1'b0) begin errors++; $display("FAIL rr_gap_%0d: got gnt=%b done=%b expected 0000/0", i, gnt, done); end
    end
    req = '0;
    checks++; if (flags !== 8'h00) begin errors++; $display("FAIL rr_flags: got %h expected 00", flags); end
  endtask

  task automatic test_conflict();
    // Bit 0 both set and cleared while 0, bit 7 set.
    req = 4'b0010;
    set_mask[15:8] = 8'h81;
    clr_mask[15:8] = 8'h01;
    tick();
    checks++; if (gnt !== 4'b0010 || done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL conf1_pulse: got gnt=%b done=%b err=%b expected 0010/1/1", gnt, done, err); end
    req = '0;
    tick();
    checks++; if (flags !== 8'h80 || err !== 1'b0) begin errors++; $display("FAIL conf1_flags: got %h err=%b expected 80/0", flags, err); end
    // Make bit 0 a one, then conflict on it again: it must stay 1.
    set_mask = '0; clr_mask = '0;
    req = 4'b0001;
    set_mask[7:0] = 8'h01;
    tick();
    req = '0;
    tick();
    checks++; if (flags !== 8'h81) begin errors++; $display("FAIL conf_prep: got %h expected 81", flags); end
    set_mask = '0;
    req = 4'b0010;
    set_mask[15:8] = 8'h01;
    clr_mask[15:8] = 8'h01;
    tick();
    checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL conf2_pulse: got done=%b err=%b expected 1/1", done, err); end
    req = '0;
    tick();
    checks++; if (flags !== 8'h81) begin errors++; $display("FAIL conf2_flags: got %h expected 81", flags); end
    set_mask = '0; clr_mask = '0;
  endtask

  task automatic test_reset_mid_apply();
    req = 4'b1000;
    set_mask[31:24] = 8'hFF;
    tick();
    checks++; if (gnt !== 4'b1000 || done !== 1'b1) begin errors++; $display("FAIL abort_grant: got gnt=%b done=%b expected 1000/1", gnt, done); end
    rst = 1'b1;
    #2;
    checks++; if (gnt !== 4'b0000 || done !== 1'b0 || flags !== 8'h00) begin errors++; $display("FAIL abort_async: got gnt=%b done=%b flags=%h expected 0000/0/00", gnt, done, flags); end
    tick();
    checks++; if (flags !== 8'h00 || flags_bar !== 8'hFF) begin errors++; $display("FAIL abort_flags: got %h/%h expected 00/ff", flags, flags_bar); end
    rst = 1'b0;
    set_mask = '0;
    req = 4'b1010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL post_reset_grant: got %b expected 0010", gnt); end
    req = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    set_mask = '0;
    clr_mask = '0;
    #3;
    test_reset();
    test_set();
    test_clear();
    test_round_robin();
    test_conflict();
    test_reset_mid_apply();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

Interface
REQ-001 Parameters SHALL be NREQ, default 4, number of requesters; WIDTH, default 8, number of shared SR flag bits.
REQ-002 The port list SHALL be, one per line, name direction width meaning, clock and reset first:
 clk  input  1  single clock, all state on rising edge
 rst  input  1  asynchronous, active-high reset
 req  input  NREQ  per-requester request, level, held until done
 set_mask  input  NREQ*WIDTH  per-requester bits to set, slice i = [i*WIDTH +: WIDTH]
 clr_mask  input  NREQ*WIDTH  per-requester bits to clear, same slicing
 gnt  output  NREQ  one-hot grant, 0 when idle
 done  output  1  one-cycle pulse, granted command applied
 err  output  1  one-cycle pulse with done, set/clear conflict seen
 flags  output  WIDTH  shared flag register Q
 flags_bar  output  WIDTH  bitwise inverse of flags
REQ-003 The design SHALL use one clock, clk; reset SHALL be rst, asynchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE and APPLY only.
REQ-005 In IDLE with req != 0, the block SHALL pick a winner by round-robin from pointer ptr and go to APPLY. The search order SHALL be ptr, ptr+1, ... mod NREQ.
REQ-006 On entry to APPLY, the block SHALL register gnt (one-hot winner) and latch the winner's set_mask and clr_mask. Mask changes after that SHALL be ignored.
REQ-007 In APPLY, flags SHALL update on the clock edge per bit. Set-only SHALL give 1, clear-only SHALL give 0, neither SHALL hold.
REQ-008 For a bit with both set and clear asserted, the flag SHALL hold its value and never go X. err SHALL pulse if any bit conflicts.
REQ-009 done SHALL pulse for exactly the APPLY cycle. gnt SHALL stay high through APPLY and drop to 0 on return to IDLE.
REQ-010 On leaving APPLY, ptr SHALL become (winner+1) mod NREQ.
REQ-011 Latency SHALL be 1 cycle from the req-sample edge to gnt/done high. flags SHALL be visible 2 edges after req is sampled. Throughput SHALL be at most one command per 2 cycles.
REQ-012 If the winner drops req during APPLY, the latched command SHALL still complete.
REQ-013 A requester still holding req after its done SHALL be treated as a new request and arbitrated fairly.
REQ-014 Simultaneous requests SHALL be resolved solely by ptr. No requester SHALL wait more than NREQ-1 grants.
REQ-015 flags_bar SHALL equal ~flags combinationally at all times.

Reset
REQ-016 While rst=1, the block SHALL force: state=IDLE, ptr=0, gnt=0, done=0, err=0, flags=0, flags_bar=all ones, latched masks=0.
REQ-017 Reset asserted mid-APPLY SHALL abort the command with no partial flag update. The first post-reset grant SHALL favour requester 0.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding (IDLE=1'b0, APPLY=1'b1) and the default NREQ/WIDTH constants.
REQ-019 The flag storage SHALL be one sub-module, sr_flag_bank. It SHALL contain WIDTH clocked SR flops with per-bit S, R, and enable inputs, async reset to 0, and Q and Q_bar outputs.
REQ-020 sr_flag_bank SHALL receive S=set&~clr and R=clr&~set, gated by APPLY, so S=R=1 never reaches storage.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
 - Reset with no req: flags=8'h00, flags_bar=8'hFF, gnt=0, done=0.
 - req=0001, set_mask0=8'hA5: gnt=0001 and done on edge 1, flags=8'hA5 after edge 2, err=0.
 - From flags=8'hA5, req=0100, clr_mask2=8'h0F, set_mask2=8'h00: flags=8'hA0.
 - req=1111 held, all masks 0 after reset: grant order 0,1,2,3,0 with gnt and done every 2nd cycle.
 - set_mask1=clr_mask1=8'h01, set_mask1 bit7=1: bit0 unchanged, bit7=1, err=1 with done.
 - rst pulsed during APPLY of set_mask3=8'hFF: flags=8'h00, gnt=0; next grant goes to lowest active requester from 0.
